// File: rtl/store_buffer_pkg.sv
// Shared constants and types for the store buffer and the data memory it fronts.
// Optional feature macro used by the design: STORE_FWD_EN.
package store_buffer_pkg;

    localparam int unsigned SB_ADDR_W       = 32;
    localparam int unsigned SB_DATA_W       = 32;
    localparam int unsigned SB_DEPTH        = 4;
    localparam int unsigned SB_STARVE_LIMIT = 8;
    localparam int unsigned SB_MEM_WORDS    = 16;

    // What the single memory port does in a given cycle.
    typedef enum logic [1:0] {
        PORT_IDLE,
        PORT_LOAD,
        PORT_DRAIN
    } port_op_e;

    // Bits needed to index 'value' items (ceil(log2(value))).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 0;
        while ((64'd1 << w) < 64'(value)) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/sb_match.sv
// Address comparator across all pending store entries with youngest-match select.
// Entries are scanned oldest to youngest so the last match (nearest tail) wins.
module sb_match
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = SB_DEPTH,
    parameter int unsigned ADDR_W = SB_ADDR_W,
    parameter int unsigned DATA_W = SB_DATA_W,
    localparam int unsigned PTR_W = clog2(DEPTH)
) (
    input  logic [PTR_W-1:0]  head,
    input  logic [PTR_W:0]    count,
    input  logic [ADDR_W-1:0] lookup_addr,
    input  logic [ADDR_W-1:0] entry_addr [DEPTH],
    input  logic [DATA_W-1:0] entry_data [DEPTH],
    output logic              hit,
    output logic [DATA_W-1:0] hit_data
);

    logic [PTR_W-1:0] idx;

    // Walk from head by age offset; only offsets below count are live entries.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if (((PTR_W+1)'(k) < count) && (entry_addr[idx] == lookup_addr)) begin
                hit      = 1'b1;
                hit_data = entry_data[idx];
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer in front of a single-port word-addressed data memory.
// Stores drain in FIFO order when the port is not used by a load; a starvation
// counter forces one drain cycle after STARVE_LIMIT consecutive loads.
// Macro STORE_FWD_EN: defined -> loads forward from the youngest matching pending
// store; undefined -> a matching load stalls until the matching stores have drained.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH        = SB_DEPTH,
    parameter int unsigned ADDR_W       = SB_ADDR_W,
    parameter int unsigned DATA_W       = SB_DATA_W,
    parameter int unsigned STARVE_LIMIT = SB_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              st_valid,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              st_ready,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic [DATA_W-1:0] ld_data,
    output logic              ld_stall,
    output logic              empty,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam int unsigned PTR_W    = clog2(DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned STARVE_W = clog2(STARVE_LIMIT + 1);

    logic [PTR_W-1:0]    head_q, head_d;
    logic [PTR_W-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [ADDR_W-1:0]   entry_addr_q [DEPTH];
    logic [ADDR_W-1:0]   entry_addr_d [DEPTH];
    logic [DATA_W-1:0]   entry_data_q [DEPTH];
    logic [DATA_W-1:0]   entry_data_d [DEPTH];

    logic              full;
    logic              push;
    logic              pop;
    logic              force_drain;
    logic              fwd_block;
    logic              hit;
    logic [DATA_W-1:0] hit_data;
    port_op_e          op;

    assign empty       = (count_q == '0);
    assign full        = (count_q == CNT_W'(DEPTH));
    assign st_ready    = !full;
    assign force_drain = (starve_q == STARVE_W'(STARVE_LIMIT)) && !empty;

    sb_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_match (
        .head        (head_q),
        .count       (count_q),
        .lookup_addr (ld_addr),
        .entry_addr  (entry_addr_q),
        .entry_data  (entry_data_q),
        .hit         (hit),
        .hit_data    (hit_data)
    );

`ifdef STORE_FWD_EN
    assign fwd_block = 1'b0;
`else
    logic unused_hit_data;
    assign fwd_block       = hit;
    assign unused_hit_data = ^hit_data;
`endif

    // Port arbitration: a servable load wins, otherwise drain the oldest store.
    always_comb begin
        op = PORT_IDLE;
        if (ld_valid && !force_drain && !fwd_block) begin
            op = PORT_LOAD;
        end else if (!empty) begin
            op = PORT_DRAIN;
        end
    end

    // Memory strobes and load result for the chosen port operation.
    always_comb begin
        mem_read       = (op == PORT_LOAD);
        mem_write      = (op == PORT_DRAIN);
        mem_address    = '0;
        mem_write_data = '0;
        case (op)
            PORT_LOAD:  mem_address = ld_addr;
            PORT_DRAIN: begin
                mem_address    = entry_addr_q[head_q];
                mem_write_data = entry_data_q[head_q];
            end
            default: ;
        endcase
        ld_stall = ld_valid && (force_drain || fwd_block);
        ld_data  = '0;
        if (ld_valid) begin
`ifdef STORE_FWD_EN
            ld_data = hit ? hit_data : mem_read_data;
`else
            ld_data = mem_read_data;
`endif
        end
    end

    // Next-state: push at tail, pop on drain, starvation counter bookkeeping.
    always_comb begin
        push         = st_valid && !full;
        pop          = (op == PORT_DRAIN);
        entry_addr_d = entry_addr_q;
        entry_data_d = entry_data_q;
        if (push) begin
            entry_addr_d[tail_q] = st_addr;
            entry_data_d[tail_q] = st_data;
        end
        head_d  = pop  ? head_q + PTR_W'(1) : head_q;
        tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        starve_d = starve_q;
        if (empty || pop) begin
            starve_d = '0;
        end else if ((op == PORT_LOAD) && (starve_q != STARVE_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            starve_q <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            starve_q <= starve_d;
        end
    end

    // Entry storage; contents are meaningless until pushed, so no reset.
    always_ff @(posedge clk) begin
        entry_addr_q <= entry_addr_d;
        entry_data_q <= entry_data_d;
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer with a 16-word negedge-write memory model.
// Expected values come from a queue-based model of pending stores (STORE_FWD_EN aware).
module tb_store_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LIMIT = 8;
`ifdef STORE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_stall;
    logic        empty;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    store_buffer #(
        .DEPTH        (DEPTH),
        .ADDR_W       (32),
        .DATA_W       (32),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .st_valid       (st_valid),
        .st_addr        (st_addr),
        .st_data        (st_data),
        .st_ready       (st_ready),
        .ld_valid       (ld_valid),
        .ld_addr        (ld_addr),
        .ld_data        (ld_data),
        .ld_stall       (ld_stall),
        .empty          (empty),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: combinational read, write sampled on negedge.
    logic [31:0] tb_mem [16];
    logic        mem_clear;
    always @(negedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 16; i++) tb_mem[i] <= 32'h0;
        end else if (mem_write) begin
            tb_mem[mem_address[3:0]] <= mem_write_data;
        end
    end
    assign mem_read_data = tb_mem[mem_address[3:0]];

    // Reference model state.
    typedef struct { logic [31:0] a; logic [31:0] d; } st_t;
    st_t         pend [$];
    int          starve;
    logic [31:0] ref_mem [16];

    // Expectations for the current cycle.
    logic        exp_empty, exp_ready, exp_load, exp_drain, exp_stall, exp_push;
    logic [31:0] exp_ld_data, exp_addr, exp_wdata;

    int tests_run;
    int tests_failed;

    task automatic model_reset();
        pend.delete();
        starve = 0;
    endtask

    // Apply inputs for one cycle and derive what the buffer must do this cycle.
    task automatic drive_cycle(input logic stv, input logic [31:0] sta, input logic [31:0] std,
                               input logic ldv, input logic [31:0] lda);
        logic        hit, frc, blk;
        logic [31:0] hd;
        st_valid = stv; st_addr = sta; st_data = std;
        ld_valid = ldv; ld_addr = lda;
        #1;
        hit = 1'b0; hd = 32'h0;
        foreach (pend[i]) if (pend[i].a == lda) begin hit = 1'b1; hd = pend[i].d; end
        frc = (starve == LIMIT) && (pend.size() != 0);
        blk = !FWD && hit;
        exp_load    = ldv && !frc && !blk;
        exp_drain   = !exp_load && (pend.size() != 0);
        exp_stall   = ldv && !exp_load;
        exp_empty   = (pend.size() == 0);
        exp_ready   = (pend.size() < DEPTH);
        exp_push    = stv && exp_ready;
        exp_ld_data = !ldv ? 32'h0 : (FWD && hit) ? hd : ref_mem[lda[3:0]];
        exp_addr    = exp_load ? lda : exp_drain ? pend[0].a : 32'h0;
        exp_wdata   = exp_drain ? pend[0].d : 32'h0;
    endtask

    // Clock edge: retire the drained store, take the push, update the starve count.
    task automatic advance();
        int pre;
        @(posedge clk);
        pre = pend.size();
        if (exp_drain) begin
            ref_mem[pend[0].a[3:0]] = pend[0].d;
            void'(pend.pop_front());
        end
        if (pre == 0 || exp_drain) starve = 0;
        else if (exp_load && starve < LIMIT) starve++;
        if (exp_push) pend.push_back('{a: st_addr, d: st_data});
        #1;
    endtask

    task automatic drain_all();
        for (int i = 0; i < 40 && pend.size() != 0; i++) begin
            drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
            advance();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_clear = 1'b1;
        st_valid = 1'b0; st_addr = 32'h0; st_data = 32'h0;
        ld_valid = 1'b0; ld_addr = 32'h0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        mem_clear = 1'b0;
        tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty: got %b want 1", empty); end
        tests_run++; if (st_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_st_ready: got %b want 1", st_ready); end
        tests_run++; if ({mem_read, mem_write, ld_stall} !== 3'b000) begin tests_failed++; $display("FAIL reset_strobes: got %b want 000", {mem_read, mem_write, ld_stall}); end
        tests_run++; if ({mem_address, mem_write_data, ld_data} !== 96'h0) begin tests_failed++; $display("FAIL reset_buses: got %h/%h/%h want 0", mem_address, mem_write_data, ld_data); end
        reset = 1'b0;
    endtask

    task automatic test_basic_drain();
        drive_cycle(1'b1, 32'd3, 32'hAA, 1'b0, 32'h0);
        tests_run++; if (mem_write !== 1'b0 || empty !== 1'b1) begin tests_failed++; $display("FAIL basic_c0: got wr=%b empty=%b want 0/1", mem_write, empty); end
        advance();
        drive_cycle(1'b1, 32'd5, 32'hBB, 1'b0, 32'h0);
        tests_run++; if ({mem_write, mem_address, mem_write_data} !== {1'b1, 32'd3, 32'hAA}) begin tests_failed++; $display("FAIL basic_drain1: got wr=%b a=%0d d=%h want 1/3/aa", mem_write, mem_address, mem_write_data); end
        advance();
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        tests_run++; if ({mem_write, mem_address, mem_write_data} !== {1'b1, 32'd5, 32'hBB}) begin tests_failed++; $display("FAIL basic_drain2: got wr=%b a=%0d d=%h want 1/5/bb", mem_write, mem_address, mem_write_data); end
        advance();
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        tests_run++; if (empty !== 1'b1 || mem_write !== 1'b0) begin tests_failed++; $display("FAIL basic_empty: got empty=%b wr=%b want 1/0", empty, mem_write); end
        tests_run++; if (tb_mem[3] !== 32'hAA || tb_mem[5] !== 32'hBB) begin tests_failed++; $display("FAIL basic_mem: got %h/%h want aa/bb", tb_mem[3], tb_mem[5]); end
        advance();
    endtask

    task automatic test_starve();
        int n = 0;
        int first_stall = -1;
        for (int c = 0; c < 24; c++) begin
            drive_cycle(n < 5, 32'(10 + n), 32'(32'hC0 + n), 1'b1, 32'd9);
            tests_run++; if (st_ready !== exp_ready) begin tests_failed++; $display("FAIL starve_st_ready c%0d: got %b want %b", c, st_ready, exp_ready); end
            tests_run++; if (ld_stall !== exp_stall) begin tests_failed++; $display("FAIL starve_ld_stall c%0d: got %b want %b", c, ld_stall, exp_stall); end
            tests_run++; if (mem_write !== exp_drain) begin tests_failed++; $display("FAIL starve_mem_write c%0d: got %b want %b", c, mem_write, exp_drain); end
            if (c == 4) begin
                tests_run++; if (st_ready !== 1'b0) begin tests_failed++; $display("FAIL starve_full_after_4: got %b want 0", st_ready); end
            end
            if (ld_stall === 1'b1 && first_stall < 0) first_stall = c;
            if (exp_push) n++;
            advance();
        end
        tests_run++; if (first_stall != 9) begin tests_failed++; $display("FAIL starve_first_stall: got cycle %0d want 9", first_stall); end
        drain_all();
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL starve_empty: got %b want 1", empty); end
        for (int i = 0; i < 5; i++) begin
            tests_run++; if (tb_mem[10 + i] !== 32'(32'hC0 + i)) begin tests_failed++; $display("FAIL starve_mem[%0d]: got %h want %h", 10 + i, tb_mem[10 + i], 32'hC0 + i); end
        end
        advance();
    endtask

    task automatic test_forward();
        int  stalls = 0;
        bit  done = 1'b0;
        drive_cycle(1'b1, 32'd7, 32'h11, 1'b1, 32'd9); advance();
        drive_cycle(1'b1, 32'd7, 32'h22, 1'b1, 32'd9); advance();
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1'b0, 32'h0, 32'h0, 1'b1, 32'd7);
            tests_run++; if (ld_stall !== exp_stall) begin tests_failed++; $display("FAIL fwd_ld_stall i%0d: got %b want %b", i, ld_stall, exp_stall); end
            if (ld_stall === 1'b0) begin
                done = 1'b1;
                tests_run++; if (ld_data !== 32'h22) begin tests_failed++; $display("FAIL fwd_ld_data: got %h want 22", ld_data); end
            end else stalls++;
            advance();
            if (done) break;
        end
        tests_run++; if (!done || stalls != (FWD ? 0 : 2)) begin tests_failed++; $display("FAIL fwd_stall_cycles: got %0d (done=%0d) want %0d", stalls, done, FWD ? 0 : 2); end
        drain_all();
    endtask

    task automatic test_full_drain();
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, 32'(1 + i), 32'(32'hF0 + i), 1'b1, 32'd9);
            advance();
        end
        drive_cycle(1'b1, 32'd15, 32'hDEAD, 1'b0, 32'h0);
        tests_run++; if (st_ready !== 1'b0 || mem_write !== 1'b1 || mem_address !== 32'd1) begin tests_failed++; $display("FAIL full_push_ignored: got rdy=%b wr=%b a=%0d want 0/1/1", st_ready, mem_write, mem_address); end
        advance();
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        tests_run++; if (st_ready !== 1'b1 || empty !== 1'b0 || mem_address !== 32'd2) begin tests_failed++; $display("FAIL full_after_pop: got rdy=%b empty=%b a=%0d want 1/0/2", st_ready, empty, mem_address); end
        advance();
        drain_all();
        tests_run++; if (tb_mem[15] !== 32'h0) begin tests_failed++; $display("FAIL full_ignored_store: got %h want 0", tb_mem[15]); end
        for (int i = 0; i < 4; i++) begin
            tests_run++; if (tb_mem[1 + i] !== 32'(32'hF0 + i)) begin tests_failed++; $display("FAIL full_mem[%0d]: got %h want %h", 1 + i, tb_mem[1 + i], 32'hF0 + i); end
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] addrs [3] = '{32'd0, 32'd6, 32'd8};
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, addrs[i], 32'(32'hA0 + i), 1'b1, 32'd9);
            advance();
        end
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        tests_run++; if (mem_write !== 1'b1) begin tests_failed++; $display("FAIL arst_pre_drain: got %b want 1", mem_write); end
        #1 reset = 1'b1;
        #1;
        tests_run++; if (empty !== 1'b1 || mem_write !== 1'b0 || st_ready !== 1'b1) begin tests_failed++; $display("FAIL arst_immediate: got empty=%b wr=%b rdy=%b want 1/0/1", empty, mem_write, st_ready); end
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        tests_run++; if (empty !== 1'b1 || mem_write !== 1'b0) begin tests_failed++; $display("FAIL arst_after: got empty=%b wr=%b want 1/0", empty, mem_write); end
        advance();
        for (int i = 0; i < 3; i++) begin
            tests_run++; if (tb_mem[addrs[i][3:0]] !== 32'h0) begin tests_failed++; $display("FAIL arst_mem[%0d]: got %h want 0", addrs[i], tb_mem[addrs[i][3:0]]); end
        end
    endtask

    task automatic test_random_wrap();
        for (int c = 0; c < 80; c++) begin
            drive_cycle($urandom_range(0, 9) < 6, 32'($urandom_range(0, 15)), $urandom,
                        $urandom_range(0, 9) < 5, 32'($urandom_range(0, 15)));
            tests_run++; if (st_ready !== exp_ready) begin tests_failed++; $display("FAIL rand_st_ready c%0d: got %b want %b", c, st_ready, exp_ready); end
            tests_run++; if (empty !== exp_empty) begin tests_failed++; $display("FAIL rand_empty c%0d: got %b want %b", c, empty, exp_empty); end
            tests_run++; if (ld_stall !== exp_stall) begin tests_failed++; $display("FAIL rand_ld_stall c%0d: got %b want %b", c, ld_stall, exp_stall); end
            tests_run++; if ({mem_read, mem_write} !== {exp_load, exp_drain}) begin tests_failed++; $display("FAIL rand_strobes c%0d: got %b%b want %b%b", c, mem_read, mem_write, exp_load, exp_drain); end
            if (exp_load || exp_drain) begin
                tests_run++; if (mem_address !== exp_addr) begin tests_failed++; $display("FAIL rand_mem_address c%0d: got %h want %h", c, mem_address, exp_addr); end
            end
            if (exp_drain) begin
                tests_run++; if (mem_write_data !== exp_wdata) begin tests_failed++; $display("FAIL rand_wdata c%0d: got %h want %h", c, mem_write_data, exp_wdata); end
            end
            if (!exp_stall) begin
                tests_run++; if (ld_data !== exp_ld_data) begin tests_failed++; $display("FAIL rand_ld_data c%0d: got %h want %h", c, ld_data, exp_ld_data); end
            end
            advance();
        end
        drain_all();
        for (int i = 0; i < 16; i++) begin
            tests_run++; if (tb_mem[i] !== ref_mem[i]) begin tests_failed++; $display("FAIL rand_mem[%0d]: got %h want %h", i, tb_mem[i], ref_mem[i]); end
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_basic_drain();
        test_starve();
        test_forward();
        test_full_drain();
        test_async_reset();
        test_random_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within time budget");
        $fatal(1);
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the MEM-stage pipeline register and the single-port word-addressed data memory (16 x 32-bit).
- Accepts stores from the pipeline in one cycle and drains them to memory in FIFO order during cycles the memory port is not needed by a load.
- Supplies load data, including youngest-match forwarding from pending stores.

Parameters:
DEPTH, 4, number of buffered stores; power of two, 2..16
ADDR_W, 32, address width; word address
DATA_W, 32, data width
STARVE_LIMIT, 8, consecutive load-occupied cycles with a non-empty buffer before one drain cycle is forced

Ports:
clk  input  1  pipeline clock; state updates on posedge
reset  input  1  reset, asynchronous, active-high
st_valid  input  1  store request this cycle
st_addr  input  ADDR_W  store word address
st_data  input  DATA_W  store data
st_ready  output  1  buffer can accept a store (= !full)
ld_valid  input  1  load request this cycle
ld_addr  input  ADDR_W  load word address
ld_data  output  DATA_W  load result, combinational
ld_stall  output  1  load not served this cycle; pipeline must hold and retry
empty  output  1  no pending stores
mem_read  output  1  to data memory
mem_write  output  1  to data memory; memory samples on negedge clk
mem_address  output  ADDR_W  to data memory
mem_write_data  output  DATA_W  to data memory
mem_read_data  input  DATA_W  from data memory, combinational

Behaviour:
- Storage: DEPTH entries {addr, data}; head/tail pointers of log2(DEPTH) bits wrap modulo DEPTH; count of log2(DEPTH)+1 bits.
- Reset (async): head = tail = count = 0; starve counter = 0; empty = 1, st_ready = 1, mem_write = 0, mem_read = 0, ld_stall = 0, mem_address = 0, mem_write_data = 0, ld_data = 0. Entry contents are not reset.
- Reset mid-operation discards all pending stores. No drain occurs.
- Port arbitration (combinational, per cycle):
  - LOAD cycle: ld_valid && !force && !fwd_block -> mem_read = 1, mem_address = ld_addr, mem_write = 0.
  - DRAIN cycle: otherwise, if !empty -> mem_write = 1, mem_address = head.addr, mem_write_data = head.data, mem_read = 0.
  - Otherwise: all memory strobes 0.
- Pop: on the posedge ending a DRAIN cycle, head++ and count--.
- Push: on posedge, if st_valid && st_ready, write the entry at tail, then tail++ and count++.
  - st_valid while full is ignored. The pipeline must hold the store itself.
  - Push and pop in the same cycle leave count unchanged.
  - st_ready reflects the pre-edge count only; no same-cycle pop credit.
- Load data: a load has zero latency. If any valid entry matches ld_addr, ld_data = data of the youngest matching entry (nearest tail). Otherwise ld_data = mem_read_data.
  - A store pushed in the same cycle is not visible to a load in that cycle.
  - When ld_valid = 0, ld_data = 0.
- ld_stall = ld_valid && (force || fwd_block).
- Starve counter:
  - Increments on each LOAD cycle with count != 0; saturates at STARVE_LIMIT.
  - force = (counter == STARVE_LIMIT) && !empty.
  - Clears on every DRAIN cycle and whenever empty.
  - Net effect: after STARVE_LIMIT back-to-back loads, exactly one drain cycle is taken, then the counter restarts.
- Boundaries:
  - Wrap-around of head/tail is transparent.
  - Full with no loads drains at 1 entry/cycle.
  - A store is never lost or reordered; memory sees stores in program order.

Optional Feature:
- STORE_FWD_EN defined: youngest-match forwarding as above; fwd_block = 0.
- STORE_FWD_EN undefined:
  - No forwarding muxes; ld_data = mem_read_data.
  - fwd_block = any valid entry matches ld_addr, so the load stalls and the cycle becomes a DRAIN cycle until no match remains.
  - Starve counter behaviour is unchanged.

Decomposition:
- Shared package/header: ADDR_W/DATA_W defaults, DEPTH default, and the pointer-width function clog2. The data memory uses the same address/data constants.
- One natural sub-module, sb_match: a combinational DEPTH-way address comparator plus youngest-match priority select, parameterised by DEPTH. It returns hit and hit_data. Without STORE_FWD_EN only hit is used.

Test Plan:
- Reset, then push stores (addr 3, data 0xAA) and (addr 5, data 0xBB) with no loads -> mem_write on the next two cycles, addr 3 then 5, with the matching data; empty = 1 afterwards; memory words 3 = 0xAA, 5 = 0xBB.
- Five stores back-to-back while ld_valid = 1 to addr 9 every cycle (DEPTH = 4) -> st_ready = 0 after the 4th push; the 5th store is held; on the 9th load cycle ld_stall = 1 with one drain; no store is lost.
- Store addr 7 = 0x11, then store addr 7 = 0x22, then load addr 7 while both are pending -> with STORE_FWD_EN, ld_data = 0x22 and ld_stall = 0; without it, ld_stall = 1 for 2 cycles, then ld_data = 0x22 from memory.
- Full buffer, st_valid and a DRAIN in the same cycle -> push ignored (st_ready = 0); count = 3 next cycle; st_ready = 1.
- Assert reset asynchronously with 3 entries pending mid-cycle -> empty = 1 and mem_write = 0 immediately; memory is unchanged for the discarded stores.
- 20 pushes/pops with a continuous trickle -> pointers wrap; memory contents match the program-order reference model.
